// File: rtl/la_uart_pkg.sv
// Shared state encodings and defaults for the UART command wrapper.
// Helper baud_load() converts a clock count into a down-counter reload value.
package la_uart_pkg;

  localparam int unsigned BAUD_DIV_DEFAULT = 434;
  localparam int unsigned TIMEOUT_DEFAULT  = 65535;

  typedef enum logic [1:0] {
    RX_IDLE,
    RX_START,
    RX_DATA,
    RX_STOP
  } rx_state_e;

  typedef enum logic [1:0] {
    TX_IDLE,
    TX_START,
    TX_DATA,
    TX_STOP
  } tx_state_e;

  typedef enum logic {
    ASM_HIGH,
    ASM_LOW
  } asm_state_e;

  // Counters run down to zero, so an interval of N clocks reloads with N-1.
  function automatic logic [15:0] baud_load(input int unsigned clocks);
    return 16'(clocks - 1);
  endfunction

endpackage

// File: rtl/uart_rx.sv
// 8N1 receiver: two-flop synchronizer, mid-bit sampling, one-cycle rx_rdy_o
// strobe per byte with a good stop bit; glitches and framing errors are dropped.
module uart_rx
  import la_uart_pkg::*;
#(
  parameter int unsigned BAUD_DIV = BAUD_DIV_DEFAULT
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic       rx_i,
  output logic       rx_rdy_o,
  output logic [7:0] rx_data_o
);

  localparam logic [15:0] HALF_LOAD = baud_load(BAUD_DIV / 2);
  localparam logic [15:0] BIT_LOAD  = baud_load(BAUD_DIV);

  if (BAUD_DIV < 4 || BAUD_DIV > 65535) begin : g_bad_baud
    $error("uart_rx: BAUD_DIV must lie in 4..65535");
  end

  logic [1:0]  sync_q;
  logic        prev_q;
  logic        rx_s;
  rx_state_e   state_q, state_d;
  logic [15:0] cnt_q, cnt_d;
  logic [2:0]  bit_q, bit_d;
  logic [7:0]  shift_q, shift_d;
  logic        rdy_q, rdy_d;
  logic [7:0]  data_q, data_d;

  assign rx_s = sync_q[1];

  // Preset high so reset never looks like a start edge.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      sync_q <= 2'b11;
      prev_q <= 1'b1;
    end else begin
      sync_q <= {sync_q[0], rx_i};
      prev_q <= rx_s;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= RX_IDLE;
      cnt_q   <= '0;
      bit_q   <= '0;
      shift_q <= '0;
      rdy_q   <= 1'b0;
      data_q  <= '0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      bit_q   <= bit_d;
      shift_q <= shift_d;
      rdy_q   <= rdy_d;
      data_q  <= data_d;
    end
  end

  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    bit_d   = bit_q;
    shift_d = shift_q;
    rdy_d   = 1'b0;
    data_d  = data_q;
    unique case (state_q)
      RX_IDLE: begin
        if (prev_q && !rx_s) begin
          state_d = RX_START;
          cnt_d   = HALF_LOAD;
        end
      end
      RX_START: begin
        if (cnt_q == '0) begin
          if (rx_s) begin
            state_d = RX_IDLE;
          end else begin
            state_d = RX_DATA;
            cnt_d   = BIT_LOAD;
            bit_d   = '0;
          end
        end else begin
          cnt_d = cnt_q - 16'd1;
        end
      end
      RX_DATA: begin
        if (cnt_q == '0) begin
          shift_d = {rx_s, shift_q[7:1]};
          cnt_d   = BIT_LOAD;
          if (bit_q == 3'd7) begin
            state_d = RX_STOP;
          end else begin
            bit_d = bit_q + 3'd1;
          end
        end else begin
          cnt_d = cnt_q - 16'd1;
        end
      end
      RX_STOP: begin
        if (cnt_q == '0) begin
          state_d = RX_IDLE;
          if (rx_s) begin
            rdy_d  = 1'b1;
            data_d = shift_q;
          end
        end else begin
          cnt_d = cnt_q - 16'd1;
        end
      end
      default: state_d = RX_IDLE;
    endcase
  end

  assign rx_rdy_o  = rdy_q;
  assign rx_data_o = data_q;

endmodule

// File: rtl/uart_cmd_wrapper.sv
// Two-byte command assembler on top of uart_rx plus an 8N1 response transmitter.
// Define UART_CMD_TIMEOUT_EN to abandon a half-received command after TIMEOUT_CYCLES.
module uart_cmd_wrapper
  import la_uart_pkg::*;
#(
  parameter int unsigned BAUD_DIV       = BAUD_DIV_DEFAULT,
  parameter int unsigned TIMEOUT_CYCLES = TIMEOUT_DEFAULT
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        RX,
  output logic        TX,
  output logic [15:0] cmd,
  output logic        cmd_rdy,
  input  logic        clr_cmd_rdy,
  input  logic [7:0]  resp,
  input  logic        send_resp,
  output logic        resp_sent
);

  localparam logic [15:0] BIT_LOAD = baud_load(BAUD_DIV);

  if (BAUD_DIV < 4 || BAUD_DIV > 65535 || TIMEOUT_CYCLES < 1) begin : g_bad_param
    $error("uart_cmd_wrapper: BAUD_DIV must lie in 4..65535, TIMEOUT_CYCLES >= 1");
  end

  logic       rx_rdy;
  logic [7:0] rx_data;

  uart_rx #(
    .BAUD_DIV (BAUD_DIV)
  ) u_rx (
    .clk       (clk),
    .rst_n     (rst_n),
    .rx_i      (RX),
    .rx_rdy_o  (rx_rdy),
    .rx_data_o (rx_data)
  );

  asm_state_e  asm_q, asm_d;
  logic [15:0] cmd_q, cmd_d;
  logic        cmd_rdy_q, cmd_rdy_d;
  logic        timeout;

`ifdef UART_CMD_TIMEOUT_EN
  logic [31:0] to_cnt_q, to_cnt_d;

  always_comb begin
    to_cnt_d = '0;
    timeout  = 1'b0;
    if (asm_q == ASM_LOW && !rx_rdy) begin
      if (to_cnt_q == TIMEOUT_CYCLES - 1) begin
        timeout = 1'b1;
      end else begin
        to_cnt_d = to_cnt_q + 32'd1;
      end
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      to_cnt_q <= '0;
    end else begin
      to_cnt_q <= to_cnt_d;
    end
  end
`else
  assign timeout = 1'b0;
`endif

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      asm_q     <= ASM_HIGH;
      cmd_q     <= '0;
      cmd_rdy_q <= 1'b0;
    end else begin
      asm_q     <= asm_d;
      cmd_q     <= cmd_d;
      cmd_rdy_q <= cmd_rdy_d;
    end
  end

  // A byte arriving while the previous command is unconsumed is lost outright.
  always_comb begin
    asm_d     = asm_q;
    cmd_d     = cmd_q;
    cmd_rdy_d = cmd_rdy_q;
    if (clr_cmd_rdy) begin
      cmd_rdy_d = 1'b0;
    end
    if (rx_rdy && !cmd_rdy_q) begin
      unique case (asm_q)
        ASM_HIGH: begin
          cmd_d[15:8] = rx_data;
          asm_d       = ASM_LOW;
        end
        ASM_LOW: begin
          cmd_d[7:0] = rx_data;
          cmd_rdy_d  = 1'b1;
          asm_d      = ASM_HIGH;
        end
        default: asm_d = ASM_HIGH;
      endcase
    end else if (timeout) begin
      asm_d = ASM_HIGH;
    end
  end

  assign cmd     = cmd_q;
  assign cmd_rdy = cmd_rdy_q;

  tx_state_e   tx_state_q, tx_state_d;
  logic [15:0] tx_cnt_q, tx_cnt_d;
  logic [2:0]  tx_bit_q, tx_bit_d;
  logic [7:0]  tx_shift_q, tx_shift_d;
  logic        tx_line_q, tx_line_d;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      tx_state_q <= TX_IDLE;
      tx_cnt_q   <= '0;
      tx_bit_q   <= '0;
      tx_shift_q <= '0;
      tx_line_q  <= 1'b1;
    end else begin
      tx_state_q <= tx_state_d;
      tx_cnt_q   <= tx_cnt_d;
      tx_bit_q   <= tx_bit_d;
      tx_shift_q <= tx_shift_d;
      tx_line_q  <= tx_line_d;
    end
  end

  always_comb begin
    tx_state_d = tx_state_q;
    tx_cnt_d   = tx_cnt_q;
    tx_bit_d   = tx_bit_q;
    tx_shift_d = tx_shift_q;
    tx_line_d  = tx_line_q;
    resp_sent  = 1'b0;
    unique case (tx_state_q)
      TX_IDLE: begin
        if (send_resp) begin
          tx_shift_d = resp;
          tx_cnt_d   = BIT_LOAD;
          tx_line_d  = 1'b0;
          tx_state_d = TX_START;
        end
      end
      TX_START: begin
        if (tx_cnt_q == '0) begin
          tx_state_d = TX_DATA;
          tx_cnt_d   = BIT_LOAD;
          tx_bit_d   = '0;
          tx_line_d  = tx_shift_q[0];
        end else begin
          tx_cnt_d = tx_cnt_q - 16'd1;
        end
      end
      TX_DATA: begin
        if (tx_cnt_q == '0) begin
          tx_cnt_d = BIT_LOAD;
          if (tx_bit_q == 3'd7) begin
            tx_state_d = TX_STOP;
            tx_line_d  = 1'b1;
          end else begin
            tx_bit_d   = tx_bit_q + 3'd1;
            tx_shift_d = tx_shift_q >> 1;
            tx_line_d  = tx_shift_q[1];
          end
        end else begin
          tx_cnt_d = tx_cnt_q - 16'd1;
        end
      end
      TX_STOP: begin
        if (tx_cnt_q == '0) begin
          resp_sent = 1'b1;
          // Back-to-back: a request in the last stop cycle starts the next frame directly.
          if (send_resp) begin
            tx_shift_d = resp;
            tx_cnt_d   = BIT_LOAD;
            tx_line_d  = 1'b0;
            tx_state_d = TX_START;
          end else begin
            tx_state_d = TX_IDLE;
          end
        end else begin
          tx_cnt_d = tx_cnt_q - 16'd1;
        end
      end
      default: tx_state_d = TX_IDLE;
    endcase
  end

  assign TX = tx_line_q;

endmodule
